// File: rtl/mac_sequencer.sv
// ----------------------------------------------------------------------------
// mac_sequencer
//
// Front end for a MAC_WIDTH x MAC_WIDTH systolic MAC matrix. When it gets a
// start command it does three things in order:
//   1. Loads one weight row per cycle from the weight memory into the matrix.
//   2. Streams activation vectors into the matrix with a diagonal skew.
//   3. De-skews the column outputs into aligned result vectors.
// It then pulses done. No arithmetic is done here; data passes unmodified.
//
// Ports
//   clock, reset        single clock, synchronous active-high reset
//   start, num_vectors  job command; num_vectors is sampled with start
//   busy, done          status: busy outside IDLE, one-cycle done at job end
//   w_rd_en, w_addr     weight memory read port
//   w_rdata             weight row data, valid one cycle after w_rd_en
//   instr               matrix mode: 1 = weight load, 0 = compute
//   weight_row_valid    weight_row_data is written into row weight_row_sel
//   weight_row_sel, weight_row_data
//   act_valid, act_ready, act_data
//                       activation vector handshake
//   values_to_array     skewed lanes to the matrix
//   values_from_array   column outputs from the matrix
//   out_valid, out_data aligned result vector, no backpressure
// ----------------------------------------------------------------------------
module mac_sequencer #(
  parameter int DATA_SIZE = 8,
  parameter int MAC_WIDTH = 256,
  parameter int ARRAY_LAT = MAC_WIDTH,
  parameter int AW        = $clog2(MAC_WIDTH)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [15:0]                    num_vectors,
  output logic                           busy,
  output logic                           done,
  output logic                           w_rd_en,
  output logic [AW-1:0]                  w_addr,
  input  logic [MAC_WIDTH*DATA_SIZE-1:0] w_rdata,
  output logic                           instr,
  output logic                           weight_row_valid,
  output logic [AW-1:0]                  weight_row_sel,
  output logic [MAC_WIDTH*DATA_SIZE-1:0] weight_row_data,
  input  logic                           act_valid,
  output logic                           act_ready,
  input  logic [MAC_WIDTH*DATA_SIZE-1:0] act_data,
  output logic [MAC_WIDTH*DATA_SIZE-1:0] values_to_array,
  input  logic [MAC_WIDTH*DATA_SIZE-1:0] values_from_array,
  output logic                           out_valid,
  output logic [MAC_WIDTH*DATA_SIZE-1:0] out_data
);

  localparam int VW = MAC_WIDTH * DATA_SIZE;
  // Latency from acceptance to the aligned result:
  //   1 cycle into the skew stage
  //   ARRAY_LAT cycles through the matrix
  //   MAC_WIDTH cycles of skew plus de-skew
  localparam int LAT = ARRAY_LAT + MAC_WIDTH + 1;
  localparam logic [AW-1:0] LAST_ROW = AW'(MAC_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [15:0]   num_latched;
  logic [15:0]   vec_cnt;
  logic [AW-1:0] row_cnt;
  logic          rd_done;
  logic          wr_valid;
  logic [AW-1:0] wr_sel;
  logic          transfer;
  logic [LAT-1:0] token;
  logic [VW-1:0] skew_in;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control outputs.
  // The LOAD state lasts one cycle past the last read so that the final row
  // fetched from memory is still written while instr is held at 1.
  // DRAIN ignores the tail stage of the token pipe. A token sitting in the
  // tail stage is emitted as out_valid in that same cycle, so done can follow
  // the last result directly.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    w_rd_en    = 1'b0;
    w_addr     = '0;
    instr      = 1'b0;
    act_ready  = 1'b0;
    transfer   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        busy    = 1'b1;
        instr   = 1'b1;
        w_rd_en = !rd_done;
        w_addr  = rd_done ? '0 : row_cnt;
        if (wr_valid && (wr_sel == LAST_ROW)) begin
          state_next = (num_latched == 16'd0) ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        busy      = 1'b1;
        act_ready = (vec_cnt != num_latched);
        transfer  = act_valid && act_ready;
        if (transfer && ((vec_cnt + 16'd1) == num_latched)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (token[LAT-2:0] == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Job counters and the one-cycle-delayed weight write.
  // The row counter saturates at the last row. rd_done marks that every
  // row has been requested.
  always_ff @(posedge clock) begin
    if (reset) begin
      num_latched <= '0;
      vec_cnt     <= '0;
      row_cnt     <= '0;
      rd_done     <= 1'b0;
      wr_valid    <= 1'b0;
      wr_sel      <= '0;
    end else begin
      wr_valid <= w_rd_en;
      wr_sel   <= w_addr;
      if ((state == IDLE) && start) begin
        num_latched <= num_vectors;
        vec_cnt     <= '0;
        row_cnt     <= '0;
        rd_done     <= 1'b0;
      end else begin
        if (w_rd_en) begin
          if (row_cnt == LAST_ROW) begin
            rd_done <= 1'b1;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        if (transfer) begin
          vec_cnt <= vec_cnt + 16'd1;
        end
      end
    end
  end

  assign weight_row_valid = wr_valid;
  assign weight_row_sel   = wr_sel;
  assign weight_row_data  = wr_valid ? w_rdata : '0;

  // A cycle without a transfer injects zeros, so the matrix only ever sees
  // real vectors or clean bubbles.
  assign skew_in = transfer ? act_data : '0;

  // Token pipe: one bit per accepted vector, aligned with out_data.
  always_ff @(posedge clock) begin
    if (reset) begin
      token <= '0;
    end else begin
      token <= {token[LAT-2:0], transfer};
    end
  end

  assign out_valid = token[LAT-1];

  // Skew: lane i is delayed by i+1 registers, which forms the diagonal
  // wavefront into the matrix.
  for (genvar i = 0; i < MAC_WIDTH; i++) begin : g_skew
    logic [DATA_SIZE-1:0] stage [0:i];

    always_ff @(posedge clock) begin
      if (reset) begin
        for (int k = 0; k <= i; k++) begin
          stage[k] <= '0;
        end
      end else begin
        stage[0] <= skew_in[i*DATA_SIZE +: DATA_SIZE];
        for (int k = 1; k <= i; k++) begin
          stage[k] <= stage[k-1];
        end
      end
    end

    assign values_to_array[i*DATA_SIZE +: DATA_SIZE] = stage[i];
  end

  // De-skew: column j is delayed by MAC_WIDTH-j registers. Later columns
  // arrive later from the matrix and get a shorter delay, so every column of
  // one vector lands on out_data in the same cycle.
  for (genvar j = 0; j < MAC_WIDTH; j++) begin : g_deskew
    localparam int D = MAC_WIDTH - j;
    logic [DATA_SIZE-1:0] stage [0:D-1];

    always_ff @(posedge clock) begin
      if (reset) begin
        for (int k = 0; k < D; k++) begin
          stage[k] <= '0;
        end
      end else begin
        stage[0] <= values_from_array[j*DATA_SIZE +: DATA_SIZE];
        for (int k = 1; k < D; k++) begin
          stage[k] <= stage[k-1];
        end
      end
    end

    assign out_data[j*DATA_SIZE +: DATA_SIZE] = stage[D-1];
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mac_sequencer
//
// Directed bench for mac_sequencer, configured as a 4x4 array with
// ARRAY_LAT=4. The matrix is modelled as a pure ARRAY_LAT-cycle delay, so the
// aligned results must equal the accepted activation vectors. Every job
// starts with start high in cycle 0 and then records 32 cycles of outputs.
// Each test task compares those records against cycle numbers worked out
// by hand.
// ----------------------------------------------------------------------------
module tb_mac_sequencer;

  localparam int DS = 8;
  localparam int MW = 4;
  localparam int AL = 4;
  localparam int AWB = 2;
  localparam int VW = MW * DS;
  localparam int NC = 32;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic [15:0]    num_vectors;
  logic           busy;
  logic           done;
  logic           w_rd_en;
  logic [AWB-1:0] w_addr;
  logic [VW-1:0]  w_rdata;
  logic           instr;
  logic           weight_row_valid;
  logic [AWB-1:0] weight_row_sel;
  logic [VW-1:0]  weight_row_data;
  logic           act_valid;
  logic           act_ready;
  logic [VW-1:0]  act_data;
  logic [VW-1:0]  values_to_array;
  logic [VW-1:0]  values_from_array;
  logic           out_valid;
  logic [VW-1:0]  out_data;

  int checks = 0;
  int passes = 0;

  logic [63:0] vmask;
  logic [VW-1:0] dat [0:63];
  int extra_start;
  int reset_at;

  logic          tr_busy [0:NC-1];
  logic          tr_done [0:NC-1];
  logic          tr_rden [0:NC-1];
  logic [31:0]   tr_addr [0:NC-1];
  logic          tr_instr [0:NC-1];
  logic          tr_wv [0:NC-1];
  logic [31:0]   tr_sel [0:NC-1];
  logic [VW-1:0] tr_wdata [0:NC-1];
  logic          tr_ready [0:NC-1];
  logic [VW-1:0] tr_vta [0:NC-1];
  logic          tr_ov [0:NC-1];
  logic [VW-1:0] tr_od [0:NC-1];

  mac_sequencer #(
    .DATA_SIZE(DS),
    .MAC_WIDTH(MW),
    .ARRAY_LAT(AL),
    .AW(AWB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .num_vectors(num_vectors),
    .busy(busy),
    .done(done),
    .w_rd_en(w_rd_en),
    .w_addr(w_addr),
    .w_rdata(w_rdata),
    .instr(instr),
    .weight_row_valid(weight_row_valid),
    .weight_row_sel(weight_row_sel),
    .weight_row_data(weight_row_data),
    .act_valid(act_valid),
    .act_ready(act_ready),
    .act_data(act_data),
    .values_to_array(values_to_array),
    .values_from_array(values_from_array),
    .out_valid(out_valid),
    .out_data(out_data)
  );

  always #5 clock = ~clock;

  function automatic logic [VW-1:0] wrow(input int a);
    return 32'h0F1E2D3C + 32'(a) * 32'h01010101;
  endfunction

  // Weight memory: data one cycle after the read, garbage otherwise.
  always @(posedge clock) begin
    w_rdata <= w_rd_en ? wrow(int'(w_addr)) : 32'hDEADBEEF;
  end

  // Matrix stand-in: every lane is a pure ARRAY_LAT-cycle delay.
  logic [VW-1:0] arr [0:AL-1];
  always @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < AL; k++) arr[k] <= '0;
    end else begin
      arr[0] <= values_to_array;
      for (int k = 1; k < AL; k++) arr[k] <= arr[k-1];
    end
  end
  assign values_from_array = arr[AL-1];

  // Runs one job with start in cycle 0 and records NC cycles of outputs.
  task automatic run_job(input logic [15:0] nv);
    @(posedge clock); #1;
    for (int c = 0; c < NC; c++) begin
      start = (c == 0) || (c == extra_start);
      if (c == 0) num_vectors = nv;
      if (c == extra_start) num_vectors = 16'd7;
      reset = (c == reset_at);
      act_valid = vmask[c];
      act_data = dat[c];
      @(negedge clock);
      tr_busy[c]  = busy;
      tr_done[c]  = done;
      tr_rden[c]  = w_rd_en;
      tr_addr[c]  = 32'(w_addr);
      tr_instr[c] = instr;
      tr_wv[c]    = weight_row_valid;
      tr_sel[c]   = 32'(weight_row_sel);
      tr_wdata[c] = weight_row_data;
      tr_ready[c] = act_ready;
      tr_vta[c]   = values_to_array;
      tr_ov[c]    = out_valid;
      tr_od[c]    = out_data;
      @(posedge clock); #1;
    end
    start = 1'b0;
    act_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic fill_data();
    for (int c = 0; c < 64; c++) dat[c] = 32'h10203040 + 32'(c) * 32'h01010101;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    act_valid = 1'b0;
    num_vectors = '0;
    act_data = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%0d exp=0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done got=%0d exp=0", done); else passes++;
    checks++; if (w_rd_en !== 1'b0) $display("[TB] FAIL reset_w_rd_en got=%0d exp=0", w_rd_en); else passes++;
    checks++; if (w_addr !== '0) $display("[TB] FAIL reset_w_addr got=%0d exp=0", w_addr); else passes++;
    checks++; if (instr !== 1'b0) $display("[TB] FAIL reset_instr got=%0d exp=0", instr); else passes++;
    checks++; if (weight_row_valid !== 1'b0) $display("[TB] FAIL reset_wr_valid got=%0d exp=0", weight_row_valid); else passes++;
    checks++; if (weight_row_sel !== '0) $display("[TB] FAIL reset_wr_sel got=%0d exp=0", weight_row_sel); else passes++;
    checks++; if (weight_row_data !== '0) $display("[TB] FAIL reset_wr_data got=%h exp=0", weight_row_data); else passes++;
    checks++; if (act_ready !== 1'b0) $display("[TB] FAIL reset_act_ready got=%0d exp=0", act_ready); else passes++;
    checks++; if (values_to_array !== '0) $display("[TB] FAIL reset_vta got=%h exp=0", values_to_array); else passes++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got=%0d exp=0", out_valid); else passes++;
    checks++; if (out_data !== '0) $display("[TB] FAIL reset_out_data got=%h exp=0", out_data); else passes++;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  // num_vectors=0: weight load only, then straight to DRAIN and done at 7.
  task automatic test_zero_vectors();
    logic e;
    extra_start = -1; reset_at = -1;
    vmask = '1;
    fill_data();
    run_job(16'd0);
    for (int c = 0; c < NC; c++) begin
      e = (c >= 1 && c <= 4);
      checks++; if (tr_rden[c] !== e) $display("[TB] FAIL zv_w_rd_en c=%0d got=%0d exp=%0d", c, tr_rden[c], e); else passes++;
      if (e) begin
        checks++; if (tr_addr[c] !== 32'(c - 1)) $display("[TB] FAIL zv_w_addr c=%0d got=%0d exp=%0d", c, tr_addr[c], c - 1); else passes++;
      end
      e = (c >= 2 && c <= 5);
      checks++; if (tr_wv[c] !== e) $display("[TB] FAIL zv_wr_valid c=%0d got=%0d exp=%0d", c, tr_wv[c], e); else passes++;
      if (e) begin
        checks++; if (tr_sel[c] !== 32'(c - 2)) $display("[TB] FAIL zv_wr_sel c=%0d got=%0d exp=%0d", c, tr_sel[c], c - 2); else passes++;
        checks++; if (tr_wdata[c] !== wrow(c - 2)) $display("[TB] FAIL zv_wr_data c=%0d got=%h exp=%h", c, tr_wdata[c], wrow(c - 2)); else passes++;
      end
      e = (c >= 1 && c <= 5);
      checks++; if (tr_instr[c] !== e) $display("[TB] FAIL zv_instr c=%0d got=%0d exp=%0d", c, tr_instr[c], e); else passes++;
      e = (c >= 1 && c <= 7);
      checks++; if (tr_busy[c] !== e) $display("[TB] FAIL zv_busy c=%0d got=%0d exp=%0d", c, tr_busy[c], e); else passes++;
      e = (c == 7);
      checks++; if (tr_done[c] !== e) $display("[TB] FAIL zv_done c=%0d got=%0d exp=%0d", c, tr_done[c], e); else passes++;
      checks++; if (tr_ready[c] !== 1'b0) $display("[TB] FAIL zv_act_ready c=%0d got=%0d exp=0", c, tr_ready[c]); else passes++;
      checks++; if (tr_ov[c] !== 1'b0) $display("[TB] FAIL zv_out_valid c=%0d got=%0d exp=0", c, tr_ov[c]); else passes++;
    end
  endtask

  // Three back-to-back vectors: ready 6..8, results 15..17, done at 18.
  task automatic test_stream();
    logic e;
    extra_start = -1; reset_at = -1;
    vmask = '1;
    fill_data();
    run_job(16'd3);
    for (int c = 0; c < NC; c++) begin
      e = (c >= 6 && c <= 8);
      checks++; if (tr_ready[c] !== e) $display("[TB] FAIL st_act_ready c=%0d got=%0d exp=%0d", c, tr_ready[c], e); else passes++;
      e = (c >= 15 && c <= 17);
      checks++; if (tr_ov[c] !== e) $display("[TB] FAIL st_out_valid c=%0d got=%0d exp=%0d", c, tr_ov[c], e); else passes++;
      if (e) begin
        checks++; if (tr_od[c] !== dat[c - 9]) $display("[TB] FAIL st_out_data c=%0d got=%h exp=%h", c, tr_od[c], dat[c - 9]); else passes++;
      end
      e = (c == 18);
      checks++; if (tr_done[c] !== e) $display("[TB] FAIL st_done c=%0d got=%0d exp=%0d", c, tr_done[c], e); else passes++;
      e = (c >= 1 && c <= 18);
      checks++; if (tr_busy[c] !== e) $display("[TB] FAIL st_busy c=%0d got=%0d exp=%0d", c, tr_busy[c], e); else passes++;
    end
  endtask

  // act_valid 1,0,1 in STREAM: results at 15 and 17, a zero bubble at 16.
  // The valid in cycle 3 falls in LOAD and must not be accepted.
  task automatic test_bubbles();
    logic e;
    extra_start = -1; reset_at = -1;
    vmask = '0;
    vmask[3] = 1'b1;
    vmask[6] = 1'b1;
    vmask[8] = 1'b1;
    fill_data();
    run_job(16'd2);
    for (int c = 0; c < NC; c++) begin
      e = (c >= 6 && c <= 8);
      checks++; if (tr_ready[c] !== e) $display("[TB] FAIL bb_act_ready c=%0d got=%0d exp=%0d", c, tr_ready[c], e); else passes++;
      e = (c == 15 || c == 17);
      checks++; if (tr_ov[c] !== e) $display("[TB] FAIL bb_out_valid c=%0d got=%0d exp=%0d", c, tr_ov[c], e); else passes++;
      e = (c == 18);
      checks++; if (tr_done[c] !== e) $display("[TB] FAIL bb_done c=%0d got=%0d exp=%0d", c, tr_done[c], e); else passes++;
    end
    checks++; if (tr_od[15] !== dat[6]) $display("[TB] FAIL bb_data15 got=%h exp=%h", tr_od[15], dat[6]); else passes++;
    checks++; if (tr_od[16] !== '0) $display("[TB] FAIL bb_data16 got=%h exp=0", tr_od[16]); else passes++;
    checks++; if (tr_od[17] !== dat[8]) $display("[TB] FAIL bb_data17 got=%h exp=%h", tr_od[17], dat[8]); else passes++;
  endtask

  // Lanes {4,3,2,1} accepted at cycle 6: lane i shows i+1 only at 7+i.
  task automatic test_skew();
    logic [7:0] e8;
    extra_start = -1; reset_at = -1;
    vmask = '0;
    vmask[6] = 1'b1;
    for (int c = 0; c < 64; c++) dat[c] = 32'hAABBCCDD;
    dat[6] = 32'h04030201;
    run_job(16'd1);
    for (int c = 0; c < NC; c++) begin
      for (int i = 0; i < MW; i++) begin
        e8 = (c == 7 + i) ? 8'(i + 1) : 8'h00;
        checks++; if (tr_vta[c][i*DS +: DS] !== e8) $display("[TB] FAIL sk_lane%0d c=%0d got=%h exp=%h", i, c, tr_vta[c][i*DS +: DS], e8); else passes++;
      end
      checks++; if (tr_ov[c] !== (c == 15)) $display("[TB] FAIL sk_out_valid c=%0d got=%0d exp=%0d", c, tr_ov[c], c == 15); else passes++;
      checks++; if (tr_done[c] !== (c == 16)) $display("[TB] FAIL sk_done c=%0d got=%0d exp=%0d", c, tr_done[c], c == 16); else passes++;
    end
    checks++; if (tr_od[15] !== 32'h04030201) $display("[TB] FAIL sk_out_data got=%h exp=04030201", tr_od[15]); else passes++;
  endtask

  // A start in cycle 7 (with num_vectors=7) must change nothing.
  task automatic test_start_while_busy();
    logic e;
    extra_start = 7; reset_at = -1;
    vmask = '1;
    fill_data();
    run_job(16'd3);
    for (int c = 0; c < NC; c++) begin
      e = (c >= 6 && c <= 8);
      checks++; if (tr_ready[c] !== e) $display("[TB] FAIL sb_act_ready c=%0d got=%0d exp=%0d", c, tr_ready[c], e); else passes++;
      e = (c >= 15 && c <= 17);
      checks++; if (tr_ov[c] !== e) $display("[TB] FAIL sb_out_valid c=%0d got=%0d exp=%0d", c, tr_ov[c], e); else passes++;
      e = (c == 18);
      checks++; if (tr_done[c] !== e) $display("[TB] FAIL sb_done c=%0d got=%0d exp=%0d", c, tr_done[c], e); else passes++;
      e = (c >= 1 && c <= 18);
      checks++; if (tr_busy[c] !== e) $display("[TB] FAIL sb_busy c=%0d got=%0d exp=%0d", c, tr_busy[c], e); else passes++;
    end
    extra_start = -1;
  endtask

  // Reset in cycle 7 (second STREAM cycle): all quiet from cycle 8 on.
  task automatic test_reset_midjob();
    extra_start = -1; reset_at = 7;
    vmask = '1;
    fill_data();
    run_job(16'd3);
    checks++; if (tr_busy[8] !== 1'b0) $display("[TB] FAIL rm_busy got=%0d exp=0", tr_busy[8]); else passes++;
    checks++; if (tr_ready[8] !== 1'b0) $display("[TB] FAIL rm_act_ready got=%0d exp=0", tr_ready[8]); else passes++;
    checks++; if (tr_instr[8] !== 1'b0) $display("[TB] FAIL rm_instr got=%0d exp=0", tr_instr[8]); else passes++;
    checks++; if (tr_rden[8] !== 1'b0) $display("[TB] FAIL rm_w_rd_en got=%0d exp=0", tr_rden[8]); else passes++;
    checks++; if (tr_wv[8] !== 1'b0) $display("[TB] FAIL rm_wr_valid got=%0d exp=0", tr_wv[8]); else passes++;
    checks++; if (tr_wdata[8] !== '0) $display("[TB] FAIL rm_wr_data got=%h exp=0", tr_wdata[8]); else passes++;
    checks++; if (tr_vta[8] !== '0) $display("[TB] FAIL rm_vta got=%h exp=0", tr_vta[8]); else passes++;
    checks++; if (tr_od[8] !== '0) $display("[TB] FAIL rm_out_data got=%h exp=0", tr_od[8]); else passes++;
    for (int c = 8; c < NC; c++) begin
      checks++; if (tr_ov[c] !== 1'b0) $display("[TB] FAIL rm_out_valid c=%0d got=%0d exp=0", c, tr_ov[c]); else passes++;
      checks++; if (tr_busy[c] !== 1'b0) $display("[TB] FAIL rm_busy_late c=%0d got=%0d exp=0", c, tr_busy[c]); else passes++;
      checks++; if (tr_done[c] !== 1'b0) $display("[TB] FAIL rm_done c=%0d got=%0d exp=0", c, tr_done[c]); else passes++;
    end
    reset_at = -1;
  endtask

  // A fresh job after the mid-job reset must run normally.
  task automatic test_after_reset();
    logic e;
    extra_start = -1; reset_at = -1;
    vmask = '1;
    for (int c = 0; c < 64; c++) dat[c] = 32'h55AA0000 + 32'(c) * 32'h00000103;
    run_job(16'd3);
    for (int c = 0; c < NC; c++) begin
      e = (c >= 6 && c <= 8);
      checks++; if (tr_ready[c] !== e) $display("[TB] FAIL ar_act_ready c=%0d got=%0d exp=%0d", c, tr_ready[c], e); else passes++;
      e = (c >= 15 && c <= 17);
      checks++; if (tr_ov[c] !== e) $display("[TB] FAIL ar_out_valid c=%0d got=%0d exp=%0d", c, tr_ov[c], e); else passes++;
      if (e) begin
        checks++; if (tr_od[c] !== dat[c - 9]) $display("[TB] FAIL ar_out_data c=%0d got=%h exp=%h", c, tr_od[c], dat[c - 9]); else passes++;
      end
      e = (c == 18);
      checks++; if (tr_done[c] !== e) $display("[TB] FAIL ar_done c=%0d got=%0d exp=%0d", c, tr_done[c], e); else passes++;
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    act_valid = 1'b0;
    act_data = '0;
    num_vectors = '0;
    vmask = '0;
    extra_start = -1;
    reset_at = -1;
    test_reset();
    test_zero_vectors();
    test_stream();
    test_bubbles();
    test_skew();
    test_start_while_busy();
    test_reset_midjob();
    test_after_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Control and data-staging front end for the MAC_WIDTH x MAC_WIDTH systolic MAC matrix. On a start command it loads one weight row per cycle from the weight memory into the matrix, then streams activation vectors into the matrix with diagonal skew. It de-skews the column outputs into aligned result vectors and reports completion. It sits between the TPU top-level control, the weight/activation buffers and the matrix's values_in1/values_out1 plane.

## Interface
- DATA_SIZE, 8, element width in bits
- MAC_WIDTH, 256, array dimension (rows = columns = lanes)
- ARRAY_LAT, MAC_WIDTH, cycles from a lane-0 element entering the array to column 0 output appearing on values_from_array
- AW, $clog2(MAC_WIDTH), weight row address width
- clock  in  1  single clock, all logic posedge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle command pulse; ignored unless IDLE
- num_vectors  in  16  activation vectors per job, sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- w_rd_en  out  1  weight memory read strobe
- w_addr  out  AW  weight row address
- w_rdata  in  MAC_WIDTH*DATA_SIZE  row data, valid 1 cycle after w_rd_en
- instr  out  1  matrix mode: 1 = weight load, 0 = compute
- weight_row_valid  out  1  weight_row_data is to be written into row weight_row_sel
- weight_row_sel  out  AW  target matrix row
- weight_row_data  out  MAC_WIDTH*DATA_SIZE  row weights, element j in bits [j*DATA_SIZE +: DATA_SIZE]
- act_valid  in  1  activation vector offered
- act_ready  out  1  sequencer accepts act_data this cycle
- act_data  in  MAC_WIDTH*DATA_SIZE  activation vector, lane i in bits [i*DATA_SIZE +: DATA_SIZE]
- values_to_array  out  MAC_WIDTH*DATA_SIZE  skewed lanes, to matrix values_in1
- values_from_array  in  MAC_WIDTH*DATA_SIZE  column outputs, from matrix values_out1
- out_valid  out  1  out_data holds one aligned result vector
- out_data  out  MAC_WIDTH*DATA_SIZE  de-skewed result, column j in bits [j*DATA_SIZE +: DATA_SIZE]

## Operation
- Reset values: state IDLE, every output 0, all skew/de-skew registers and the token pipe 0, counters 0.
- FSM states: IDLE, LOAD, STREAM, DRAIN, DONE.
- IDLE -> LOAD on start. Latch num_vectors and clear the row counter.
- LOAD:
  - w_rd_en=1 with w_addr = 0..MAC_WIDTH-1 on consecutive cycles.
  - One cycle later: weight_row_valid=1, weight_row_sel = that address, weight_row_data = w_rdata.
  - instr=1 throughout LOAD. It is 0 in every other state, including IDLE.
  - After the last row is written, go to STREAM. If num_vectors=0, go straight to DRAIN.
- STREAM:
  - act_ready=1 while accepted count < num_vectors.
  - Transfer happens when act_valid && act_ready.
  - A transferred vector pushes act_data into the skew stage and a 1 into the token pipe.
  - A cycle with no transfer pushes all-zero data and a 0 token.
  - When the count reaches num_vectors, go to DRAIN.
- Skew: lane i passes through i+1 registers (lane 0 is registered once). Active in every state. Zeros are injected outside STREAM transfers.
- De-skew: column j of values_from_array passes through MAC_WIDTH-j registers, so all columns align on out_data.
- Token pipe: LAT = ARRAY_LAT + MAC_WIDTH + 1 stages deep. out_valid = token at its tail.
- DRAIN: wait until the token pipe is all zero (no pending out_valid), then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- The sequencer performs no arithmetic; data passes unmodified.
- Outputs have no backpressure. The consumer must take every out_valid cycle.

## Timing
- start sampled at cycle 0: LOAD in cycles 1..MAC_WIDTH with w_rd_en high. weight_row_valid is high in cycles 2..MAC_WIDTH+1.
- STREAM begins at cycle MAC_WIDTH+2. act_ready is combinational from state and count, never from act_valid.
- A vector accepted at cycle t produces out_valid at cycle t+LAT. Consecutive accepted vectors give consecutive out_valid cycles. Bubbles are preserved.
- done fires the cycle after the last out_valid (DRAIN exits when the pipe is empty). With num_vectors=0, done is at cycle MAC_WIDTH+3.
- start while busy has no effect. num_vectors is not re-sampled.
- Reset asserted mid-job: at the next edge the block is in IDLE, all outputs are 0, and in-flight tokens and data are discarded (no out_valid after reset).
- Counter wrap: the row counter stops at MAC_WIDTH-1. The 16-bit vector count compares with equality and never wraps; 65535 is legal.

## Test plan
- MAC_WIDTH=4, ARRAY_LAT=4, start with num_vectors=0 -> w_addr 0,1,2,3 in cycles 1-4; weight_row_sel 0..3 in cycles 2-5; done at cycle 7; no act_ready or out_valid.
- Same config, num_vectors=3, act_valid held high, matrix model = pass-through delay -> act_ready at cycles 6,7,8; out_valid at 15,16,17 with out_data equal to the inputs; done at 18.
- Bubbles: act_valid toggles 1,0,1 -> out_valid pattern 1,0,1 at LAT offset; the zero-lane data is never flagged valid.
- Skew check: act_data lanes {4,3,2,1} accepted at t -> values_to_array lane i equals lane i's value exactly at t+1+i and is zero elsewhere.
- start pulsed during STREAM -> ignored; transfer count and done timing unchanged.
- Reset asserted at the 2nd STREAM cycle -> next cycle busy=0, all outputs 0, no later out_valid; a fresh start then runs normally.
